ctu_set_mc: RTL and testbench
=============================

Name: ctu_set_mc

Overview:
Multi-channel, order-preserving set for CTU event vectors. Each channel holds unique keys in FIFO order. A write of a key already present in that channel is dropped, and every write reports accepted, duplicate or overflow. Pops are first-word-fall-through and clear membership. A global flush sequencer clears all channels. Sits between event generators and the CTU scheduler, where it replaces single-channel sets.

Parameters:
DATA_WD, 11, width of one entry
KEY_HI, 10, MSB of the key field within an entry
KEY_LO, 0, LSB of the key field; KEY_WD = KEY_HI-KEY_LO+1
DEPTH, 128, entries per channel FIFO
LEN_WD, 8, length counter width; must hold DEPTH
CHANNELS, 2, number of independent sets
CH_WD, 1, channel index width; 2^CH_WD >= CHANNELS

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high
wr  in  1  write request
wr_ch  in  CH_WD  write channel
wr_data  in  DATA_WD  entry to insert
wr_ok  out  1  pulse: entry inserted (1 cycle after wr)
wr_dup  out  1  pulse: key already present, entry dropped
wr_ovf  out  1  pulse: channel full, entry dropped
rd  in  1  pop request
rd_ch  in  CH_WD  pop channel
rd_data  out  DATA_WD  head entry of rd_ch; 0 if empty
clr  in  1  flush request (pulse)
busy  out  1  flush in progress
empty  out  CHANNELS  per-channel empty
full  out  CHANNELS  per-channel full
length  out  CHANNELS*LEN_WD  per-channel occupancy; channel c at [c*LEN_WD +: LEN_WD]
dup_cnt  out  16  duplicate counter (optional feature)

Behaviour:
- Reset: all FIFOs empty, membership bitmap all 0, length=0, empty=all 1, full=0, wr_ok/wr_dup/wr_ovf=0, busy=0, rd_data=0, FSM=IDLE.
- Storage per channel: FIFO of DEPTH entries plus a 2^KEY_WD x 1 membership bitmap indexed by wr_data[KEY_HI:KEY_LO].
- Write pipeline, 2 stages:
  - S1 (cycle of wr): bitmap lookup; ch/data registered.
  - S2 (next cycle): exactly one of wr_ok/wr_dup/wr_ovf pulses.
  - Precedence: dup over ovf. If the key is present, wr_dup pulses even when the channel is full.
  - On ok: entry pushed and bit set. length and empty update in the same edge as wr_ok.
- Throughput: wr is accepted every cycle. Results must equal sequential semantics in acceptance order. Back-to-back writes of the same key/channel give ok then dup (forwarding from S2 into S1 required).
- Ordering rule: a pop accepted in the same cycle as a write's S1 or S2 is ordered before that write. So a write of the popping head key gives ok.
- Overflow: full counts the S2-pending insert; a write that would exceed DEPTH gives wr_ovf.
- Pops: rd_data combinational from the head of rd_ch. rd on an empty channel is ignored. A pop clears the head key's bit in that same edge.
- Simultaneous wr and rd on the same or different channels are allowed.
- Channel index: wr_ch or rd_ch >= CHANNELS is ignored. No result pulse is produced for such a write.
- FSM: IDLE -> CLEAR on clr (from IDLE only).
  - On entry: all FIFOs reset, any S2-pending write discarded (no pulse).
  - CLEAR: sweeps index 0..2^KEY_WD-1, zeroing that bitmap row in all channels, 1 index/cycle; busy=1 throughout.
  - CLEAR -> IDLE after the last index; busy drops the following cycle.
  - While busy: wr, rd and clr are ignored.
- rst mid-flush: immediate return to the reset state.

Optional Feature:
CTU_SET_STATS_EN:
- Defined: dup_cnt increments on each wr_dup, saturates at 16'hFFFF, and clears on rst or flush entry.
- Undefined: no counter logic; dup_cnt tied to 0.

Test Plan:
- CHANNELS=2, DEPTH=4: wr ch0 0x005 then ch0 0x005 back-to-back -> wr_ok at cycle 1, wr_dup at cycle 2, length[ch0]=1.
- Write 0x005 to ch0 and ch1 -> both wr_ok. Channels are independent, each length=1.
- Fill ch0 with 0x001..0x004, then wr 0x007 -> wr_ovf, full[0]=1. Then wr 0x002 -> wr_dup, not ovf.
- ch0 holds 0x003; assert rd ch0 and wr ch0 0x003 in the same cycle -> rd_data=0x003, then wr_ok, length stays 1.
- clr with entries present -> busy=1 for 2048 cycles (KEY_WD=11), empty=all 1. Writes during busy are ignored. Afterwards, a re-write of an old key -> wr_ok.
- With CTU_SET_STATS_EN defined: 3 duplicate writes -> dup_cnt=3; then clr -> dup_cnt=0.

Source files
------------

// File: rtl/ctu_set_mc_if.sv
// ctu_set_mc_if: write/pop bus of the multi-channel CTU event set.
// master = event generator / scheduler side, slave = the set itself.
interface ctu_set_mc_if #(
    parameter int DATA_WD = 11,
    parameter int CH_WD   = 1
);
    logic               wr;
    logic [CH_WD-1:0]   wr_ch;
    logic [DATA_WD-1:0] wr_data;
    logic               wr_ok;
    logic               wr_dup;
    logic               wr_ovf;
    logic               rd;
    logic [CH_WD-1:0]   rd_ch;
    logic [DATA_WD-1:0] rd_data;

    modport master (
        output wr, wr_ch, wr_data, rd, rd_ch,
        input  wr_ok, wr_dup, wr_ovf, rd_data
    );

    modport slave (
        input  wr, wr_ch, wr_data, rd, rd_ch,
        output wr_ok, wr_dup, wr_ovf, rd_data
    );
endinterface

// File: rtl/ctu_set_mc.sv
// ctu_set_mc: multi-channel order-preserving set of CTU event keys.
// Each channel is a FIFO of unique keys backed by a membership bitmap.
// Writes report ok/dup/ovf one cycle later; pops are first-word-fall-through.
// A flush sweeps the bitmap one key index per cycle while busy is high.
// Optional: define CTU_SET_STATS_EN to enable the saturating dup_cnt counter;
// otherwise dup_cnt is tied to zero.
module ctu_set_mc #(
    parameter int DATA_WD  = 11,
    parameter int KEY_HI   = 10,
    parameter int KEY_LO   = 0,
    parameter int DEPTH    = 128,
    parameter int LEN_WD   = 8,
    parameter int CHANNELS = 2,
    parameter int CH_WD    = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    ctu_set_mc_if.slave                  bus,
    input  logic                         clr,
    output logic                         busy,
    output logic [CHANNELS-1:0]          empty,
    output logic [CHANNELS-1:0]          full,
    output logic [CHANNELS*LEN_WD-1:0]   length,
    output logic [15:0]                  dup_cnt
);
    localparam int KEY_WD = KEY_HI - KEY_LO + 1;
    localparam int KEYS   = 1 << KEY_WD;
    localparam int PTR_WD = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CH_WD:0]    CH_LIM   = (CH_WD + 1)'(CHANNELS);
    localparam logic [LEN_WD-1:0] LEN_MAX  = LEN_WD'(DEPTH);
    localparam logic [PTR_WD-1:0] PTR_LAST = PTR_WD'(DEPTH - 1);

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    state_t              state_q;
    logic                busy_q;
    logic [KEY_WD-1:0]   sweep_q;
    logic                ok_q;
    logic                dup_q;
    logic                ovf_q;

    logic [DATA_WD-1:0]  mem_q  [CHANNELS][DEPTH];
    logic [CHANNELS-1:0] bmp_q  [KEYS];
    logic [PTR_WD-1:0]   head_q [CHANNELS];
    logic [PTR_WD-1:0]   tail_q [CHANNELS];
    logic [LEN_WD-1:0]   len_q  [CHANNELS];

    logic                accept;
    logic                wr_ch_ok;
    logic                rd_ch_ok;
    logic [CH_WD-1:0]    wr_idx;
    logic [CH_WD-1:0]    rd_idx;
    logic [DATA_WD-1:0]  head_data;
    logic [KEY_WD-1:0]   wr_key;
    logic [KEY_WD-1:0]   pop_key;
    logic                rd_has;
    logic                pop_v;
    logic                wr_v;
    logic                pop_same;
    logic                key_hit;
    logic                ch_full;
    logic                wr_ok_d;
    logic                wr_dup_d;
    logic                wr_ovf_d;

    function automatic logic [PTR_WD-1:0] ptr_next(input logic [PTR_WD-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Request decode and write outcome; a same-cycle pop on the write's
    // channel is applied first, so its head key and slot are already freed.
    always_comb begin
        accept    = (state_q == ST_IDLE) && !clr;
        wr_ch_ok  = {1'b0, bus.wr_ch} < CH_LIM;
        rd_ch_ok  = {1'b0, bus.rd_ch} < CH_LIM;
        wr_idx    = wr_ch_ok ? bus.wr_ch : '0;
        rd_idx    = rd_ch_ok ? bus.rd_ch : '0;
        head_data = mem_q[rd_idx][head_q[rd_idx]];
        rd_has    = rd_ch_ok && (len_q[rd_idx] != '0);
        pop_v     = accept && bus.rd && rd_has;
        pop_key   = head_data[KEY_HI:KEY_LO];
        wr_key    = bus.wr_data[KEY_HI:KEY_LO];
        wr_v      = accept && bus.wr && wr_ch_ok;
        pop_same  = pop_v && (rd_idx == wr_idx);
        key_hit   = bmp_q[wr_key][wr_idx] && !(pop_same && (pop_key == wr_key));
        ch_full   = (len_q[wr_idx] == LEN_MAX) && !pop_same;
        wr_dup_d  = wr_v && key_hit;
        wr_ovf_d  = wr_v && !key_hit && ch_full;
        wr_ok_d   = wr_v && !key_hit && !ch_full;
    end

    // Flush FSM plus FIFO/bitmap state; write results registered into pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            sweep_q <= '0;
            ok_q    <= 1'b0;
            dup_q   <= 1'b0;
            ovf_q   <= 1'b0;
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                head_q[c] <= '0;
                tail_q[c] <= '0;
                len_q[c]  <= '0;
            end
            for (int unsigned k = 0; k < KEYS; k++) begin
                bmp_q[k] <= '0;
            end
        end else begin
            ok_q  <= wr_ok_d;
            dup_q <= wr_dup_d;
            ovf_q <= wr_ovf_d;
            case (state_q)
                ST_IDLE: begin
                    if (clr) begin
                        // Any write presented alongside clr is dropped without a pulse.
                        state_q <= ST_CLEAR;
                        busy_q  <= 1'b1;
                        sweep_q <= '0;
                        for (int unsigned c = 0; c < CHANNELS; c++) begin
                            head_q[c] <= '0;
                            tail_q[c] <= '0;
                            len_q[c]  <= '0;
                        end
                    end else begin
                        if (pop_v) begin
                            head_q[rd_idx]         <= ptr_next(head_q[rd_idx]);
                            bmp_q[pop_key][rd_idx] <= 1'b0;
                        end
                        // Placed after the pop so a re-write of the popped key keeps its bit.
                        if (wr_ok_d) begin
                            mem_q[wr_idx][tail_q[wr_idx]] <= bus.wr_data;
                            tail_q[wr_idx]                <= ptr_next(tail_q[wr_idx]);
                            bmp_q[wr_key][wr_idx]         <= 1'b1;
                        end
                        for (int unsigned c = 0; c < CHANNELS; c++) begin
                            len_q[c] <= len_q[c]
                                      + LEN_WD'(wr_ok_d && (wr_idx == CH_WD'(c)))
                                      - LEN_WD'(pop_v && (rd_idx == CH_WD'(c)));
                        end
                    end
                end
                ST_CLEAR: begin
                    bmp_q[sweep_q] <= '0;
                    sweep_q        <= sweep_q + 1'b1;
                    if (sweep_q == '1) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Per-channel status flattened onto the output vectors.
    always_comb begin
        empty  = '0;
        full   = '0;
        length = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            empty[c]                   = (len_q[c] == '0);
            full[c]                    = (len_q[c] == LEN_MAX);
            length[c*LEN_WD +: LEN_WD] = len_q[c];
        end
    end

    assign bus.wr_ok   = ok_q;
    assign bus.wr_dup  = dup_q;
    assign bus.wr_ovf  = ovf_q;
    assign bus.rd_data = rd_has ? head_data : '0;
    assign busy        = busy_q;

`ifdef CTU_SET_STATS_EN
    logic [15:0] dup_cnt_q;

    // Saturating duplicate counter, cleared on reset and on flush entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            dup_cnt_q <= '0;
        end else if ((state_q == ST_IDLE) && clr) begin
            dup_cnt_q <= '0;
        end else if (wr_dup_d && (dup_cnt_q != '1)) begin
            dup_cnt_q <= dup_cnt_q + 16'd1;
        end
    end

    assign dup_cnt = dup_cnt_q;
`else
    assign dup_cnt = '0;
`endif
endmodule

// File: tb/tb_ctu_set_mc.sv
// tb_ctu_set_mc: directed bench for ctu_set_mc (CHANNELS=2, DEPTH=4, 11-bit keys).
// A queue-style model of each channel is stepped on every clock edge and
// compared against the DUT on every falling edge; directed literal checks
// pin the model. Define CTU_SET_STATS_EN to also exercise dup_cnt.
module tb_ctu_set_mc;
    localparam int DW    = 11;
    localparam int CH    = 2;
    localparam int DEP   = 4;
    localparam int LW    = 8;
    localparam int NKEYS = 2048;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clr = 1'b0;
    logic              busy;
    logic [CH-1:0]     empty;
    logic [CH-1:0]     full;
    logic [CH*LW-1:0]  length;
    logic [15:0]       dup_cnt;

    ctu_set_mc_if #(.DATA_WD(DW), .CH_WD(1)) bus ();

    ctu_set_mc #(
        .DATA_WD (DW),
        .KEY_HI  (10),
        .KEY_LO  (0),
        .DEPTH   (DEP),
        .LEN_WD  (LW),
        .CHANNELS(CH),
        .CH_WD   (1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .clr    (clr),
        .busy   (busy),
        .empty  (empty),
        .full   (full),
        .length (length),
        .dup_cnt(dup_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: each channel is an ordered list; the key spans the whole entry.
    logic [DW-1:0] ment [CH][DEP];
    int            mcnt [CH];
    int            mbusy;
    int            mdup;
    logic          m_ok, m_dup, m_ovf;
    bit            mvalid = 1'b0;

    // Sequential semantics: pop first, then the write, in acceptance order.
    always @(posedge clk) begin
        int  rc;
        int  wc;
        bit  found;
        mvalid = 1'b1;
        m_ok   = 1'b0;
        m_dup  = 1'b0;
        m_ovf  = 1'b0;
        rc     = int'(bus.rd_ch);
        wc     = int'(bus.wr_ch);
        if (rst) begin
            mcnt  = '{0, 0};
            mbusy = 0;
            mdup  = 0;
        end else if (mbusy > 0) begin
            mbusy--;
        end else if (clr) begin
            mcnt  = '{0, 0};
            mbusy = NKEYS;
            mdup  = 0;
        end else begin
            if (bus.rd && mcnt[rc] > 0) begin
                for (int i = 0; i < DEP - 1; i++) ment[rc][i] = ment[rc][i+1];
                mcnt[rc]--;
            end
            if (bus.wr) begin
                found = 1'b0;
                for (int i = 0; i < mcnt[wc]; i++)
                    if (ment[wc][i] == bus.wr_data) found = 1'b1;
                if (found) begin
                    m_dup = 1'b1;
                    if (mdup < 65535) mdup++;
                end else if (mcnt[wc] == DEP) begin
                    m_ovf = 1'b1;
                end else begin
                    ment[wc][mcnt[wc]] = bus.wr_data;
                    mcnt[wc]++;
                    m_ok = 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        logic [DW-1:0]    exp_rd;
        logic [CH*LW-1:0] exp_len;
        logic [CH-1:0]    exp_empty;
        logic [CH-1:0]    exp_full;
        if (mvalid) begin
            exp_rd    = (mcnt[int'(bus.rd_ch)] > 0) ? ment[int'(bus.rd_ch)][0] : '0;
            exp_len   = {8'(mcnt[1]), 8'(mcnt[0])};
            exp_empty = {mcnt[1] == 0, mcnt[0] == 0};
            exp_full  = {mcnt[1] == DEP, mcnt[0] == DEP};
            check("wr_ok", bus.wr_ok, m_ok);
            check("wr_dup", bus.wr_dup, m_dup);
            check("wr_ovf", bus.wr_ovf, m_ovf);
            check("rd_data", bus.rd_data, exp_rd);
            check("busy", busy, mbusy > 0);
            check("empty", empty, exp_empty);
            check("full", full, exp_full);
            check("length", length, exp_len);
`ifdef CTU_SET_STATS_EN
            check("dup_cnt", dup_cnt, 16'(mdup));
`else
            check("dup_cnt", dup_cnt, 0);
`endif
        end
    end

    task automatic step(input logic w, input logic wc, input logic [DW-1:0] wd,
                        input logic r, input logic rc, input logic c);
        bus.wr      = w;
        bus.wr_ch   = wc;
        bus.wr_data = wd;
        bus.rd      = r;
        bus.rd_ch   = rc;
        clr         = c;
        @(posedge clk);
        #1;
        bus.wr = 1'b0;
        bus.rd = 1'b0;
        clr    = 1'b0;
    endtask

    task automatic wait_flush(output int n);
        n = 0;
        while (busy && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        int n;
        bus.wr      = 1'b0;
        bus.wr_ch   = 1'b0;
        bus.wr_data = '0;
        bus.rd      = 1'b0;
        bus.rd_ch   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("lit_rst_empty", empty, 2'b11);
        check("lit_rst_length", length, 0);
        check("lit_rst_busy", busy, 0);
        check("lit_rst_rd_data", bus.rd_data, 0);
        rst = 1'b0;

        // Back-to-back writes of the same key: ok then dup.
        step(1, 0, 11'h005, 0, 0, 0);
        check("lit_b2b_ok", bus.wr_ok, 1);
        step(1, 0, 11'h005, 0, 0, 0);
        check("lit_b2b_dup", bus.wr_dup, 1);
        check("lit_b2b_ok2", bus.wr_ok, 0);
        check("lit_b2b_len", length[7:0], 1);

        // Same key in the other channel is independent.
        step(1, 1, 11'h005, 0, 0, 0);
        check("lit_ch1_ok", bus.wr_ok, 1);
        check("lit_ch1_len", length, 16'h0101);

        // Pop ch0 while writing ch1.
        step(1, 1, 11'h00A, 1, 0, 0);
        check("lit_xch_ok", bus.wr_ok, 1);
        check("lit_xch_len", length, 16'h0200);

        // Fill ch0, then overflow, then duplicate of a present key on a full channel.
        for (int k = 1; k <= 4; k++) begin
            step(1, 0, 11'(k), 0, 0, 0);
            check("lit_fill_ok", bus.wr_ok, 1);
        end
        step(1, 0, 11'h007, 0, 0, 0);
        check("lit_ovf", bus.wr_ovf, 1);
        check("lit_ovf_full", full[0], 1);
        step(1, 0, 11'h002, 0, 0, 0);
        check("lit_full_dup", bus.wr_dup, 1);
        check("lit_full_noovf", bus.wr_ovf, 0);

        // Drain ch0 in FIFO order, then hold a single 0x003.
        repeat (4) step(0, 0, '0, 1, 0, 0);
        check("lit_drain_empty", empty[0], 1);
        step(1, 0, 11'h003, 0, 0, 0);
        check("lit_head3", bus.rd_data, 11'h003);

        // Pop and re-write of the head key in the same cycle.
        step(1, 0, 11'h003, 1, 0, 0);
        check("lit_poprw_ok", bus.wr_ok, 1);
        check("lit_poprw_len", length[7:0], 1);
        check("lit_poprw_head", bus.rd_data, 11'h003);

        // Flush with writes attempted while busy.
        step(0, 0, '0, 0, 0, 1);
        check("lit_clr_busy", busy, 1);
        check("lit_clr_empty", empty, 2'b11);
        n = 0;
        while (busy && n < 3000) begin
            bus.wr      = (n < 3);
            bus.wr_ch   = 1'b0;
            bus.wr_data = 11'h003;
            @(posedge clk);
            #1;
            n++;
        end
        bus.wr = 1'b0;
        check("lit_busy_len", n, NKEYS);
        step(1, 0, 11'h003, 0, 0, 0);
        check("lit_rewrite_ok", bus.wr_ok, 1);
        check("lit_rewrite_len", length[7:0], 1);

`ifdef CTU_SET_STATS_EN
        repeat (3) step(1, 0, 11'h003, 0, 0, 0);
        check("lit_dupcnt3", dup_cnt, 3);
        step(0, 0, '0, 0, 0, 1);
        check("lit_dupcnt_clr", dup_cnt, 0);
        wait_flush(n);
        check("lit_busy_len2", n, NKEYS);
`endif

        repeat (2) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
